// File: rtl/layer_sequencer_if.sv
// Bus between the layer sequencer, its input-sample buffer and the neuron array.
// Ports: start/abort pass control, in_addr/in_data buffer read (zero latency),
//        myinput/freeze neuron drive, busy/out_valid/out_ready result handshake.
// Modports: master = sequencer side, slave = environment (buffer, neurons, consumer).
interface layer_sequencer_if #(
   parameter int dataWidth = 16,
   parameter int addrWidth = 10
);
   logic                 start;
   logic                 abort;
   logic [addrWidth-1:0] in_addr;
   logic [dataWidth-1:0] in_data;
   logic [dataWidth-1:0] myinput;
   logic                 freeze;
   logic                 busy;
   logic                 out_valid;
   logic                 out_ready;

   modport master (
      input  start, abort, in_data, out_ready,
      output in_addr, myinput, freeze, busy, out_valid
   );

   modport slave (
      output start, abort, in_data, out_ready,
      input  in_addr, myinput, freeze, busy, out_valid
   );
endinterface

// File: rtl/layer_sequencer.sv
// Purpose: sequences one layer pass - streams numWeight buffer samples to the neurons, then holds results.
// Latency: start -> first sample 1 cycle; freeze low for exactly numWeight cycles; then out_valid until out_ready.
// Backpressure: out_valid/freeze held in DONE until out_ready; start ignored while busy; abort always wins.
// Ports: clk, rst_n (async, active-low); bus (layer_sequencer_if.master) carries all pass/buffer/neuron signals.
module layer_sequencer #(
   parameter int numWeight = 784,
   parameter int dataWidth = 16,
   parameter int addrWidth = $clog2(numWeight)
) (
   input logic               clk,
   input logic               rst_n,
   layer_sequencer_if.master bus
);

   localparam int              CntW    = $clog2(numWeight + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(numWeight - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            freeze_q, freeze_d;
   logic            busy_q, busy_d;
   logic            out_valid_q, out_valid_d;
   logic [dataWidth-1:0] sample;

   // Next-state and next-output decode; every output is registered so that
   // start/out_ready never reach a port combinationally.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      freeze_d    = freeze_q;
      busy_d      = busy_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE: begin
            if (bus.start && !bus.abort) begin
               state_d  = RUN;
               cnt_d    = '0;
               freeze_d = 1'b0;
               busy_d   = 1'b1;
            end
         end
         RUN: begin
            if (bus.abort) begin
               state_d     = IDLE;
               cnt_d       = '0;
               freeze_d    = 1'b1;
               busy_d      = 1'b0;
               out_valid_d = 1'b0;
            end else if (cnt_q == CntLast) begin
               // cnt is cleared here so in_addr reads 0 throughout DONE.
               state_d     = DONE;
               cnt_d       = '0;
               freeze_d    = 1'b1;
               out_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         DONE: begin
            // Exit always lands in IDLE, which guarantees one frozen cycle
            // between passes even if start is held high.
            if (bus.abort || bus.out_ready) begin
               state_d     = IDLE;
               cnt_d       = '0;
               freeze_d    = 1'b1;
               busy_d      = 1'b0;
               out_valid_d = 1'b0;
            end
         end
         default: begin
            state_d     = IDLE;
            cnt_d       = '0;
            freeze_d    = 1'b1;
            busy_d      = 1'b0;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         freeze_q    <= 1'b1;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         freeze_q    <= freeze_d;
         busy_q      <= busy_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Zero-latency buffer: the sample for address k arrives in the same cycle,
   // matching the neuron's own weight address.
   assign sample        = bus.in_data;
   assign bus.myinput   = sample;
   assign bus.in_addr   = cnt_q[addrWidth-1:0];
   assign bus.freeze    = freeze_q;
   assign bus.busy      = busy_q;
   assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Testbench for layer_sequencer with numWeight=4: directed scenarios plus a
// randomized run compared against a pass-position reference model.
module tb_layer_sequencer;
   localparam int NW = 4;
   localparam int DW = 16;
   localparam int AW = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;
   logic [DW-1:0] mem [NW];

   layer_sequencer_if #(.dataWidth(DW), .addrWidth(AW)) bus ();

   layer_sequencer #(.numWeight(NW), .dataWidth(DW), .addrWidth(AW)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   assign bus.in_data = mem[bus.in_addr];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      bus.start = 1'b0; bus.abort = 1'b0; bus.out_ready = 1'b0;
      for (int i = 0; i < NW; i++) mem[i] = DW'(i + 1);
      rst_n = 1'b0;
      #12;
      tests++;
      if ({bus.freeze, bus.busy, bus.out_valid} !== 3'b100) begin
         fails++; $display("FAIL reset_flags: got %b want 100", {bus.freeze, bus.busy, bus.out_valid});
      end
      tests++;
      if (bus.in_addr !== 2'd0) begin
         fails++; $display("FAIL reset_addr: got %0d want 0", bus.in_addr);
      end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      tests++;
      if ({bus.freeze, bus.busy, bus.out_valid} !== 3'b100) begin
         fails++; $display("FAIL post_reset_idle: got %b want 100", {bus.freeze, bus.busy, bus.out_valid});
      end
   endtask

   task automatic test_single_pass();
      int low = 0;
      int sum = 0;
      bit addr_ok = 1'b1;
      for (int i = 0; i < NW; i++) mem[i] = DW'(i + 1);
      bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      tests++;
      if (bus.freeze !== 1'b0) begin
         fails++; $display("FAIL pass_launch: freeze got %b want 0", bus.freeze);
      end
      for (int c = 0; c < 10 && bus.out_valid !== 1'b1; c++) begin
         if (bus.freeze === 1'b0) begin
            if (bus.in_addr !== low[AW-1:0]) addr_ok = 1'b0;
            sum += int'(bus.myinput);
            low++;
         end
         @(negedge clk);
      end
      tests++;
      if (low != NW) begin
         fails++; $display("FAIL pass_len: freeze-low cycles got %0d want %0d", low, NW);
      end
      tests++;
      if (!addr_ok) begin
         fails++; $display("FAIL pass_addr: address sequence got out-of-order want 0..%0d", NW - 1);
      end
      tests++;
      if (sum != 10) begin
         fails++; $display("FAIL pass_sum: got %0d want 10", sum);
      end
      tests++;
      if ({bus.out_valid, bus.freeze, bus.busy, bus.in_addr} !== 5'b11100) begin
         fails++; $display("FAIL done_outputs: got %b want 11100", {bus.out_valid, bus.freeze, bus.busy, bus.in_addr});
      end
   endtask

   // Entered with the DUT in DONE.
   task automatic test_done_hold();
      bus.out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         tests++;
         if ({bus.out_valid, bus.freeze, bus.busy} !== 3'b111) begin
            fails++; $display("FAIL done_hold cyc%0d: got %b want 111", c, {bus.out_valid, bus.freeze, bus.busy});
         end
      end
      bus.out_ready = 1'b1;
      @(negedge clk); bus.out_ready = 1'b0;
      tests++;
      if ({bus.out_valid, bus.freeze, bus.busy} !== 3'b010) begin
         fails++; $display("FAIL done_release: got %b want 010", {bus.out_valid, bus.freeze, bus.busy});
      end
   endtask

   task automatic test_abort();
      bit seen_valid = 1'b0;
      int low = 0;
      // abort together with start in IDLE keeps the block idle
      bus.start = 1'b1; bus.abort = 1'b1;
      @(negedge clk); bus.start = 1'b0; bus.abort = 1'b0;
      tests++;
      if ({bus.busy, bus.freeze} !== 2'b01) begin
         fails++; $display("FAIL abort_start_idle: busy,freeze got %b want 01", {bus.busy, bus.freeze});
      end
      bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      tests++;
      if ({bus.freeze, bus.in_addr} !== 3'b010) begin
         fails++; $display("FAIL abort_at2_pre: freeze,addr got %b want 010", {bus.freeze, bus.in_addr});
      end
      bus.abort = 1'b1;
      @(negedge clk); bus.abort = 1'b0;
      tests++;
      if ({bus.freeze, bus.busy, bus.out_valid} !== 3'b100) begin
         fails++; $display("FAIL abort_idle: got %b want 100", {bus.freeze, bus.busy, bus.out_valid});
      end
      for (int c = 0; c < 4; c++) begin
         if (bus.out_valid === 1'b1) seen_valid = 1'b1;
         @(negedge clk);
      end
      tests++;
      if (seen_valid) begin
         fails++; $display("FAIL abort_no_valid: out_valid got 1 want 0");
      end
      bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      for (int c = 0; c < 10 && bus.out_valid !== 1'b1; c++) begin
         if (bus.freeze === 1'b0) low++;
         @(negedge clk);
      end
      tests++;
      if (low != NW || bus.out_valid !== 1'b1) begin
         fails++; $display("FAIL abort_rerun: low cycles got %0d valid %b want %0d valid 1", low, bus.out_valid, NW);
      end
      bus.out_ready = 1'b1;
      @(negedge clk); bus.out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      int run = 0;
      int gap = 0;
      int passes = 0;
      bit prev_busy = 1'b0;
      bus.start = 1'b1; bus.out_ready = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.busy === 1'b1 && !prev_busy) begin
            tests++;
            if (passes > 0 && gap < 1) begin
               fails++; $display("FAIL b2b_gap pass%0d: idle gap got %0d want >=1", passes, gap);
            end
            gap = 0;
         end
         if (bus.busy === 1'b0 && bus.freeze === 1'b1) gap++;
         if (bus.freeze === 1'b0) run++;
         else if (run != 0) begin
            tests++;
            if (run != NW) begin
               fails++; $display("FAIL b2b_runlen pass%0d: got %0d want %0d", passes, run, NW);
            end
            passes++;
            run = 0;
         end
         prev_busy = bus.busy;
      end
      tests++;
      if (passes < 5) begin
         fails++; $display("FAIL b2b_passes: got %0d want >=5", passes);
      end
      bus.start = 1'b0; bus.out_ready = 1'b0; bus.abort = 1'b1;
      @(negedge clk); bus.abort = 1'b0;
   endtask

   task automatic test_async_reset();
      bit seen_valid = 1'b0;
      bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if ({bus.freeze, bus.busy, bus.out_valid, bus.in_addr} !== 5'b10000) begin
         fails++; $display("FAIL async_reset: got %b want 10000", {bus.freeze, bus.busy, bus.out_valid, bus.in_addr});
      end
      @(negedge clk); rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1 || bus.busy === 1'b1) seen_valid = 1'b1;
      end
      tests++;
      if (seen_valid) begin
         fails++; $display("FAIL async_reset_discard: pass resumed after reset want idle");
      end
   endtask

   // Reference: pos = -1 idle, 0..NW-1 streaming sample pos, NW = results held.
   task automatic test_random();
      int pos = -1;
      logic [2:0]    exp_flags;
      logic [AW-1:0] exp_addr;
      for (int i = 0; i < NW; i++) mem[i] = DW'($urandom);
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         exp_flags = {(pos < 0 || pos == NW), (pos >= 0), (pos == NW)};
         exp_addr  = (pos >= 0 && pos < NW) ? AW'(pos) : '0;
         tests++;
         if ({bus.freeze, bus.busy, bus.out_valid, bus.in_addr} !== {exp_flags, exp_addr}) begin
            fails++; $display("FAIL rand cyc%0d: freeze,busy,valid,addr got %b want %b", c,
                              {bus.freeze, bus.busy, bus.out_valid, bus.in_addr}, {exp_flags, exp_addr});
         end
         if (pos >= 0 && pos < NW) begin
            tests++;
            if (bus.myinput !== mem[pos]) begin
               fails++; $display("FAIL rand_data cyc%0d: got %h want %h", c, bus.myinput, mem[pos]);
            end
         end
         bus.start     = ($urandom_range(0, 1) == 1);
         bus.abort     = ($urandom_range(0, 11) == 0);
         bus.out_ready = ($urandom_range(0, 2) == 0);
         if (pos < 0)            pos = (bus.start && !bus.abort) ? 0 : -1;
         else if (bus.abort)     pos = -1;
         else if (pos < NW)      pos = pos + 1;
         else if (bus.out_ready) pos = -1;
      end
      bus.start = 1'b0; bus.abort = 1'b0; bus.out_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_pass();
      test_done_hold();
      test_abort();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 Parameter numWeight, default 784, inputs per neuron (= accumulation cycles per pass); SHALL be >= 2.
REQ-002 Parameter dataWidth, default 16, width of one input sample.
REQ-003 Parameter addrWidth, default $clog2(numWeight), width of the input-buffer address.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  request one layer pass; sampled only in IDLE.
REQ-007 abort  input  1  cancel the current pass.
REQ-008 in_addr  output  addrWidth  read address to the input-sample buffer, which has zero read latency.
REQ-009 in_data  input  dataWidth  sample returned for in_addr.
REQ-010 myinput  output  dataWidth  sample broadcast to every neuron of the layer.
REQ-011 freeze  output  1  neuron hold control; 1 = frozen, 0 = accumulating.
REQ-012 busy  output  1  high in RUN and DONE.
REQ-013 out_valid  output  1  neuron sums are final and stable.
REQ-014 out_ready  input  1  downstream consumer has taken the sums.

Function
REQ-015 Three states SHALL be used: IDLE, RUN and DONE, with a counter cnt of width $clog2(numWeight+1).
REQ-016 IDLE: freeze=1, cnt=0, in_addr=0, busy=0, out_valid=0.
REQ-017 IDLE with start=1 and abort=0 SHALL go to RUN on the next edge with cnt=0.
REQ-018 RUN: freeze=0, in_addr=cnt[addrWidth-1:0], and cnt increments by 1 every cycle.
REQ-019 myinput SHALL equal in_data combinationally, so a neuron sees sample k in the same cycle its weight address is k.
REQ-020 RUN with cnt==numWeight-1 SHALL go to DONE on the next edge, so freeze is low for exactly numWeight consecutive cycles.
REQ-021 DONE: freeze=1, out_valid=1, busy=1, in_addr=0; myinput is don't-care.
REQ-022 DONE with out_ready=1 SHALL go to IDLE on the next edge; out_valid stays high until then.
REQ-023 out_ready SHALL be ignored outside DONE.
REQ-024 start SHALL be ignored in RUN and DONE; no pass is queued.
REQ-025 start asserted in the same cycle DONE exits SHALL NOT launch a pass; at least one IDLE cycle with freeze=1 separates passes, which resets the neuron address counters.
REQ-026 abort=1 in RUN or DONE SHALL force IDLE on the next edge with cnt=0 and out_valid=0; abort has priority over out_ready and over the end-of-run transition.
REQ-027 abort=1 together with start=1 in IDLE SHALL keep the block in IDLE.
REQ-028 All outputs except myinput SHALL be driven from registers or decoded state only, with no combinational path from start or out_ready.

Reset
REQ-029 rst_n=0 SHALL immediately, without waiting for a clock edge, force IDLE, cnt=0, freeze=1, busy=0 and out_valid=0.
REQ-030 Deasserting rst_n SHALL take effect at the first clock edge after deassertion; reset during RUN discards the pass.

Verification
REQ-031 numWeight=4, start pulse in IDLE -> freeze low for exactly 4 cycles with in_addr 0,1,2,3, then out_valid=1.
REQ-032 Buffer preloaded with 1,2,3,4, stub neuron accumulating myinput while freeze=0 -> sum=10 when out_valid rises.
REQ-033 out_ready held 0 for 5 cycles in DONE -> out_valid and freeze stay 1; out_ready=1 -> IDLE next cycle.
REQ-034 abort at cnt=2 -> IDLE next cycle, freeze=1, out_valid never asserted; a following start runs a full 4-cycle pass.
REQ-035 start held 1 continuously -> passes separated by at least one freeze=1 IDLE cycle, and start is ignored while busy=1.
REQ-036 rst_n pulsed low mid-RUN between clock edges -> freeze=1 and busy=0 before the next edge; no out_valid for that pass.
